// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter with independent write and read
// paths, each with its own round-robin pointer and a grant held until the response.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     m0_awaddr,
  input  logic                      m0_awvalid,
  output logic                      m0_awready,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
  input  logic                      m0_wvalid,
  output logic                      m0_wready,
  output logic                      m0_bvalid,
  input  logic                      m0_bready,
  input  logic [ADDR_WIDTH-1:0]     m0_araddr,
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
  input  logic                      m1_awvalid,
  output logic                      m1_awready,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
  input  logic                      m1_wvalid,
  output logic                      m1_wready,
  output logic                      m1_bvalid,
  input  logic                      m1_bready,
  input  logic [ADDR_WIDTH-1:0]     m1_araddr,
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  output logic [ADDR_WIDTH-1:0]     s_awaddr,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  output logic [ADDR_WIDTH-1:0]     s_araddr,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  output logic [1:0]                wgrant,
  output logic [1:0]                rgrant
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t    wstate;
  rstate_t    rstate;
  logic       wprio;
  logic       rprio;
  logic [1:0] wreq;
  logic [1:0] rreq;

  // A write only counts as a request once both AW and W are offered.
  assign wreq = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
  assign rreq = {m1_arvalid, m0_arvalid};

  function automatic logic [1:0] pick_grant(input logic [1:0] req, input logic prio);
    if (req == 2'b11) return prio ? 2'b10 : 2'b01;
    return req;
  endfunction

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate <= W_IDLE;
      wgrant <= 2'b00;
      wprio  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (|wreq) begin
            wgrant <= pick_grant(wreq, wprio);
            wstate <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (s_awvalid && s_awready && s_wvalid && s_wready) wstate <= W_RESP;
        end
        W_RESP: begin
          if (s_bvalid && s_bready) begin
            wstate <= W_IDLE;
            wprio  <= wgrant[0];
            wgrant <= 2'b00;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate <= R_IDLE;
      rgrant <= 2'b00;
      rprio  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (|rreq) begin
            rgrant <= pick_grant(rreq, rprio);
            rstate <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (s_arvalid && s_arready) rstate <= R_DATA;
        end
        R_DATA: begin
          if (s_rvalid && s_rready) begin
            rstate <= R_IDLE;
            rprio  <= rgrant[0];
            rgrant <= 2'b00;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write-side routing: AW/W only in the address phase, B only in the response phase.
  always_comb begin
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    if (wstate == W_ADDR) begin
      if (wgrant[0]) begin
        s_awaddr   = m0_awaddr;
        s_awvalid  = m0_awvalid;
        s_wdata    = m0_wdata;
        s_wstrb    = m0_wstrb;
        s_wvalid   = m0_wvalid;
        m0_awready = s_awready;
        m0_wready  = s_wready;
      end else if (wgrant[1]) begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        m1_awready = s_awready;
        m1_wready  = s_wready;
      end
    end
    if (wstate == W_RESP) begin
      if (wgrant[0]) begin
        m0_bvalid = s_bvalid;
        s_bready  = m0_bready;
      end else if (wgrant[1]) begin
        m1_bvalid = s_bvalid;
        s_bready  = m1_bready;
      end
    end
  end

  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    if (rstate == R_ADDR) begin
      if (rgrant[0]) begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
      end else if (rgrant[1]) begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
      end
    end
    if (rstate == R_DATA) begin
      if (rgrant[0]) begin
        m0_rdata  = s_rdata;
        m0_rvalid = s_rvalid;
        s_rready  = m0_rready;
      end else if (rgrant[1]) begin
        m1_rdata  = s_rdata;
        m1_rvalid = s_rvalid;
        s_rready  = m1_rready;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for axi_lite_arbiter_2to1: a register-slave model behind the arbiter and a
// reference model of memory contents and round-robin service order.
module tb_axi_lite_arbiter_2to1;
  localparam int TMO = 100;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  logic [3:0]  awaddr [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        wvalid [2];
  logic        wready [2];
  logic        bvalid [2];
  logic        bready [2];
  logic [3:0]  araddr [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata [2];
  logic        rvalid [2];
  logic        rready [2];

  logic [3:0]  s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]  s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid, s_rready;
  logic [1:0]  wgrant, rgrant;

  axi_lite_arbiter_2to1 #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
    .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(rdata[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
    .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(rdata[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wgrant(wgrant), .rgrant(rgrant)
  );

  logic any_out;
  assign any_out = |{awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1],
                     arready[0], arready[1], rvalid[0], rvalid[1], rdata[0], rdata[1],
                     s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
                     s_araddr, s_arvalid, s_rready, wgrant, rgrant};

  // Register slave: AW and W are accepted together, with random ready gaps.
  logic [31:0] smem [4];
  assign s_wready = s_awready;
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      s_awready <= 1'b0;
      s_arready <= 1'b0;
      s_bvalid  <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      for (int i = 0; i < 4; i++) smem[i] <= '0;
    end else begin
      s_awready <= ($urandom_range(0, 3) != 0);
      s_arready <= ($urandom_range(0, 3) != 0);
      if (s_awvalid && s_awready && s_wvalid && s_wready) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) smem[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        s_bvalid <= 1'b1;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        s_rdata  <= smem[s_araddr[3:2]];
        s_rvalid <= 1'b1;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // Every fresh grant (rising out of idle) is logged in service order.
  logic [1:0] wgrant_q = 2'b00;
  logic [1:0] rgrant_q = 2'b00;
  logic [1:0] wlog [$];
  logic [1:0] rlog [$];
  always @(negedge ACLK) begin
    if (wgrant != 2'b00 && wgrant_q == 2'b00) wlog.push_back(wgrant);
    if (rgrant != 2'b00 && rgrant_q == 2'b00) rlog.push_back(rgrant);
    wgrant_q <= wgrant;
    rgrant_q <= rgrant;
  end

  logic [31:0] mem [4];
  int wptr, rptr;
  int checks, errors;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    wptr = 0;
    rptr = 0;
  endtask

  task automatic m_write(input int m, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr[m] = a; wdata[m] = d; wstrb[m] = s; awvalid[m] = 1'b1; wvalid[m] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!(awready[m] && wready[m]) && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (!(awready[m] && wready[m])) begin
      errors++;
      $display("[TB] FAIL aw_w_handshake m%0d: ready=%b%b, required 11", m, awready[m], wready[m]);
    end
    @(posedge ACLK); #1;
    awvalid[m] = 1'b0; wvalid[m] = 1'b0; awaddr[m] = '0; wdata[m] = '0; wstrb[m] = '0;
    repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
    bready[m] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!bvalid[m] && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (!bvalid[m]) begin
      errors++;
      $display("[TB] FAIL b_handshake m%0d: bvalid=%b, required 1", m, bvalid[m]);
    end
    @(posedge ACLK); #1;
    bready[m] = 1'b0;
  endtask

  task automatic m_read(input int m, input logic [3:0] a, output logic [31:0] d);
    int n;
    d = '0;
    araddr[m] = a; arvalid[m] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!arready[m] && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (!arready[m]) begin
      errors++;
      $display("[TB] FAIL ar_handshake m%0d: arready=%b, required 1", m, arready[m]);
    end
    @(posedge ACLK); #1;
    arvalid[m] = 1'b0; araddr[m] = '0;
    repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
    rready[m] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!rvalid[m] && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (!rvalid[m]) begin
      errors++;
      $display("[TB] FAIL r_handshake m%0d: rvalid=%b, required 1", m, rvalid[m]);
    end
    d = rdata[m];
    @(posedge ACLK); #1;
    rready[m] = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] got;
    model_reset();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if (any_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: any output=%b, required 0", any_out);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    awaddr[0] = 4'h4; wdata[0] = 32'h12345678; wstrb[0] = 4'hF; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!(awready[0] && wready[0]) && n < TMO) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge ACLK);
    n = 0;
    while (!bvalid[0] && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (bvalid[0] !== 1'b1 || wgrant !== 2'b01) begin
      errors++;
      $display("[TB] FAIL pre_reset_wresp: bvalid=%b wgrant=%b, required 1 01", bvalid[0], wgrant);
    end
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if (any_out !== 1'b0 || wgrant !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: any output=%b wgrant=%b, required 0 00", any_out, wgrant);
    end
    awaddr[0] = '0; wdata[0] = '0; wstrb[0] = '0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    model_reset();
    // First dual request after reset: pointer is back on master 0.
    wlog.delete();
    fork
      m_write(0, 4'h8, 32'h11111111, 4'hF);
      m_write(1, 4'h8, 32'h22222222, 4'hF);
    join
    mem[2] = 32'h11111111;
    mem[2] = 32'h22222222;
    wptr = 0;
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 2'b01 || wlog[1] !== 2'b10) begin
      errors++;
      $display("[TB] FAIL post_reset_order: %0d grants first=%b, required 2 grants 01 then 10",
               wlog.size(), (wlog.size() > 0) ? wlog[0] : 2'bxx);
    end
    m_read(0, 4'h8, got);
    rptr = 1;
    checks++;
    if (got !== mem[2]) begin
      errors++;
      $display("[TB] FAIL post_reset_read: got %h, required %h", got, mem[2]);
    end
  endtask

  task automatic test_single_write();
    int n;
    logic [31:0] got;
    awaddr[0] = 4'h4; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    bready[0] = 1'b1;
    @(negedge ACLK);
    checks++;
    if (wgrant !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_idle_cycle: wgrant=%b, required 00", wgrant);
    end
    @(negedge ACLK);
    checks++;
    if (wgrant !== 2'b01 || s_awvalid !== 1'b1 || s_awaddr !== 4'h4) begin
      errors++;
      $display("[TB] FAIL single_grant: wgrant=%b s_awvalid=%b s_awaddr=%h, required 01 1 4", wgrant, s_awvalid, s_awaddr);
    end
    n = 0;
    while (!(awready[0] && wready[0]) && n < TMO) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge ACLK);
    n = 0;
    while (!bvalid[0] && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (bvalid[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_bvalid: bvalid=%b, required 1", bvalid[0]);
    end
    @(posedge ACLK); #1;
    bready[0] = 1'b0;
    mem[1] = merge(mem[1], 32'hDEADBEEF, 4'hF);
    wptr = 1;
    m_read(1, 4'h4, got);
    rptr = 0;
    checks++;
    if (got !== mem[1]) begin
      errors++;
      $display("[TB] FAIL single_readback: got %h, required %h", got, mem[1]);
    end
  endtask

  task automatic test_contention();
    logic [31:0] got;
    logic [31:0] d[2];
    int first;
    d[0] = 32'h11111111;
    d[1] = 32'h22222222;
    for (int rep = 0; rep < 2; rep++) begin
      first = wptr;
      mem[2] = d[first];
      mem[2] = d[1 - first];
      wptr = first;
      wlog.delete();
      fork
        m_write(0, 4'h8, d[0], 4'hF);
        m_write(1, 4'h8, d[1], 4'hF);
      join
      checks++;
      if (wlog.size() != 2 || wlog[0] !== 2'(1 << first) || wlog[1] !== 2'(1 << (1 - first))) begin
        errors++;
        $display("[TB] FAIL contention_order rep%0d: %0d grants first=%b, required first %b",
                 rep, wlog.size(), (wlog.size() > 0) ? wlog[0] : 2'bxx, 2'(1 << first));
      end
      m_read(1, 4'h8, got);
      rptr = 0;
      checks++;
      if (got !== mem[2]) begin
        errors++;
        $display("[TB] FAIL contention_read rep%0d: got %h, required %h", rep, got, mem[2]);
      end
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] got;
    logic [31:0] exp0;
    exp0 = mem[0];
    fork
      m_write(0, 4'hC, 32'h5A5A0C0C, 4'hF);
      m_read(1, 4'h0, got);
      begin
        int n;
        @(negedge ACLK);
        @(negedge ACLK);
        checks++;
        if (wgrant !== 2'b01 || rgrant !== 2'b10) begin
          errors++;
          $display("[TB] FAIL concurrent_grants: wgrant=%b rgrant=%b, required 01 10", wgrant, rgrant);
        end
        n = 0;
        while (!rvalid[1] && n < TMO) begin @(negedge ACLK); n++; end
        checks++;
        if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0 || bvalid[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL concurrent_isolation: m0 rvalid=%b rdata=%h m1 bvalid=%b, required 0 0 0",
                   rvalid[0], rdata[0], bvalid[1]);
        end
      end
    join
    mem[3] = merge(mem[3], 32'h5A5A0C0C, 4'hF);
    wptr = 1;
    rptr = 0;
    checks++;
    if (got !== exp0) begin
      errors++;
      $display("[TB] FAIL concurrent_read: got %h, required %h", got, exp0);
    end
    m_read(1, 4'hC, got);
    checks++;
    if (got !== mem[3]) begin
      errors++;
      $display("[TB] FAIL concurrent_write_readback: got %h, required %h", got, mem[3]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] got;
    araddr[0] = 4'h4; arvalid[0] = 1'b1; rready[0] = 1'b0;
    @(negedge ACLK);
    n = 0;
    while (!arready[0] && n < TMO) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    arvalid[0] = 1'b0; araddr[0] = '0;
    araddr[1] = 4'h8; arvalid[1] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!rvalid[0] && n < TMO) begin @(negedge ACLK); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rgrant !== 2'b01 || arready[1] !== 1'b0 || rvalid[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle%0d: rgrant=%b m1_arready=%b m0_rvalid=%b, required 01 0 1",
                 i, rgrant, arready[1], rvalid[0]);
      end
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    rready[0] = 1'b1;
    @(negedge ACLK);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== mem[1]) begin
      errors++;
      $display("[TB] FAIL bp_rdata: rvalid=%b rdata=%h, required 1 %h", rvalid[0], rdata[0], mem[1]);
    end
    @(posedge ACLK); #1;
    rready[0] = 1'b0;
    rptr = 1;
    @(negedge ACLK);
    checks++;
    if (rgrant !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_idle_after_r: rgrant=%b, required 00", rgrant);
    end
    @(negedge ACLK);
    checks++;
    if (rgrant !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_regrant: rgrant=%b, required 10", rgrant);
    end
    n = 0;
    while (!arready[1] && n < TMO) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    arvalid[1] = 1'b0; araddr[1] = '0; rready[1] = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!rvalid[1] && n < TMO) begin @(negedge ACLK); n++; end
    got = rvalid[1] ? rdata[1] : 32'hxxxxxxxx;
    @(posedge ACLK); #1;
    rready[1] = 1'b0;
    rptr = 0;
    checks++;
    if (got !== mem[2]) begin
      errors++;
      $display("[TB] FAIL bp_m1_read: got %h, required %h", got, mem[2]);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] got;
    m_write(1, 4'h0, 32'h00000000, 4'hF);
    m_write(1, 4'h0, 32'hAABBCCDD, 4'h3);
    mem[0] = merge(merge(mem[0], 32'h0, 4'hF), 32'hAABBCCDD, 4'h3);
    wptr = 0;
    m_read(0, 4'h0, got);
    rptr = 1;
    checks++;
    if (got !== mem[0]) begin
      errors++;
      $display("[TB] FAIL partial_strobe: got %h, required %h", got, mem[0]);
    end
  endtask

  task automatic test_random_traffic();
    logic [3:0]  a [2];
    logic [31:0] d [2];
    logic [31:0] got [2];
    logic [3:0]  s [2];
    int req;
    int order [$];
    for (int it = 0; it < 12; it++) begin
      req = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        a[m] = {2'($urandom_range(0, 3)), 2'b00};
        d[m] = $urandom;
        s[m] = 4'($urandom_range(0, 15));
      end
      order.delete();
      if (req == 3) begin order.push_back(wptr); order.push_back(1 - wptr); end
      else order.push_back(req == 1 ? 0 : 1);
      foreach (order[k]) begin
        mem[a[order[k]][3:2]] = merge(mem[a[order[k]][3:2]], d[order[k]], s[order[k]]);
        wptr = 1 - order[k];
      end
      wlog.delete();
      fork
        begin if (req[0]) m_write(0, a[0], d[0], s[0]); end
        begin if (req[1]) m_write(1, a[1], d[1], s[1]); end
      join
      checks++;
      if (wlog.size() != order.size()) begin
        errors++;
        $display("[TB] FAIL rand_write_grants it%0d: %0d grants, required %0d", it, wlog.size(), order.size());
      end else begin
        foreach (order[k]) begin
          checks++;
          if (wlog[k] !== 2'(1 << order[k])) begin
            errors++;
            $display("[TB] FAIL rand_write_order it%0d slot%0d: wgrant=%b, required %b", it, k, wlog[k], 2'(1 << order[k]));
          end
        end
      end
    end
    for (int it = 0; it < 10; it++) begin
      req = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) a[m] = {2'($urandom_range(0, 3)), 2'b00};
      order.delete();
      if (req == 3) begin order.push_back(rptr); order.push_back(1 - rptr); end
      else order.push_back(req == 1 ? 0 : 1);
      foreach (order[k]) rptr = 1 - order[k];
      rlog.delete();
      got[0] = '0;
      got[1] = '0;
      fork
        begin if (req[0]) m_read(0, a[0], got[0]); end
        begin if (req[1]) m_read(1, a[1], got[1]); end
      join
      checks++;
      if (rlog.size() != order.size() || rlog[0] !== 2'(1 << order[0])) begin
        errors++;
        $display("[TB] FAIL rand_read_order it%0d: %0d grants first=%b, required %0d first %b",
                 it, rlog.size(), (rlog.size() > 0) ? rlog[0] : 2'bxx, order.size(), 2'(1 << order[0]));
      end
      for (int m = 0; m < 2; m++) begin
        if (req[m]) begin
          checks++;
          if (got[m] !== mem[a[m][3:2]]) begin
            errors++;
            $display("[TB] FAIL rand_read_data it%0d m%0d addr %h: got %h, required %h", it, m, a[m], got[m], mem[a[m][3:2]]);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = '0; awvalid[m] = 1'b0; wdata[m] = '0; wstrb[m] = '0; wvalid[m] = 1'b0;
      bready[m] = 1'b0; araddr[m] = '0; arvalid[m] = 1'b0; rready[m] = 1'b0;
    end
    ARESETn = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_concurrent();
    test_backpressure();
    test_partial_strobe();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
